boot_loader_arb: RTL and testbench
==================================

// Module: boot_loader_arb
// PURPOSE
//  Owns the data-memory port and the UART RX FIFO pop line. It shares both between the CPU
//  load/store path and a boot loader.
//  After reset with boot_en=1, the loader streams a program from the RX FIFO into RAM and holds
//  the CPU stalled; the CPU is released once the load finishes.
//  After the load, all CPU memory/FIFO signals pass straight through to the memory block.
// PARAMETERS
//  BASE_ADDR  32'h0000_0100  byte address of the first loaded word (word aligned)
//  MAX_WORDS  16'd8192       maximum words accepted; larger headers are clamped
// PORTS
//  clk           in   1   system clock; all state changes on its rising edge
//  rst           in   1   synchronous reset, active-high
//  boot_en       in   1   sampled in S_IDLE: 1 = run the loader, 0 = go straight to S_RUN
//  cpu_addr      in   32  CPU data address
//  cpu_wdata     in   32  CPU store data
//  cpu_we        in   1   CPU store strobe
//  cpu_re        in   1   CPU load strobe
//  cpu_funct3    in   3   CPU load/store width code
//  cpu_rx_rdreq  in   1   FIFO pop requested by the memory block on behalf of the CPU
//  rx_empty      in   1   RX FIFO empty (show-ahead FIFO)
//  rx_data       in   8   RX FIFO head byte; valid while rx_empty=0
//  rx_rdreq      out  1   RX FIFO pop
//  mem_addr      out  32  address to the memory block
//  mem_wdata     out  32  write data to the memory block
//  mem_we        out  1   write strobe to the memory block
//  mem_re        out  1   read strobe to the memory block
//  mem_funct3    out  3   width code to the memory block
//  cpu_stall     out  1   1 = CPU must hold its PC and pipeline
//  boot_done     out  1   sticky; 1 once S_RUN has been entered
//  len_err       out  1   sticky; header length exceeded MAX_WORDS
// BEHAVIOUR
//  States:
//   S_IDLE -> S_HDR   if boot_en=1; S_IDLE -> S_RUN if boot_en=0 (one cycle after rst falls).
//   S_HDR: pops 4 bytes, little-endian, into len[31:0].
//    If len==0: -> S_RUN.
//    If len>MAX_WORDS: nwords=MAX_WORDS and len_err<=1.
//    Otherwise nwords=len. Then -> S_DATA.
//   S_DATA: pops bytes into a word register, little-endian: byte k goes to bits [8k+7:8k],
//    with k from a 2-bit byte counter.
//    On the 4th byte, a pending write is registered. The next cycle drives mem_we=1 for exactly
//    one cycle, with mem_addr = BASE_ADDR + 4*widx, mem_wdata = the word, mem_funct3 = 3'b010,
//    mem_re=0.
//    widx increments on each write. After the write with widx==nwords-1 -> S_RUN.
//   S_RUN: terminal until rst.
//  Pop rule: rx_rdreq = ~rx_empty in S_HDR/S_DATA, combinationally. Exactly one byte is consumed
//   per cycle with rx_rdreq=1. No pops once the last byte of word nwords-1 has been taken.
//   Bytes beyond the clamped length stay in the FIFO.
//  Overlap: a pending write may issue in the same cycle that the first byte of the next word is
//   popped. This must not corrupt either word, so the write data is registered.
//  Routing:
//   In S_RUN, mem_* = cpu_* and rx_rdreq = cpu_rx_rdreq (combinational, zero latency);
//    cpu_stall = 0.
//   In every other state, cpu_* and cpu_rx_rdreq are ignored; cpu_stall = 1.
//   When no loader write is active, mem_we = mem_re = 0 and mem_addr = mem_wdata = 0.
//  Reset values: state = S_IDLE, cpu_stall = 1, boot_done = 0, len_err = 0, mem_we = 0,
//   mem_re = 0, rx_rdreq = 0, counters and word register = 0.
//  Reset mid-load: the partial word is discarded and widx = 0. RAM is not cleared. The FIFO is not
//   flushed; the host must resend from the header.
//  Width rules: widx is 16 bits. Address arithmetic is 32-bit modulo 2^32; no alignment check
//   is made on BASE_ADDR.
// TESTING
//  1. boot_en=0, release rst
//     -> cycle 1: S_RUN, cpu_stall=0, boot_done=1.
//     -> cpu_we=1, cpu_addr=0x20 appears on mem_* the same cycle.
//  2. boot_en=1, FIFO holds 02 00 00 00 78 56 34 12 EF BE AD DE
//     -> write 0x12345678 @0x100, then 0xDEADBEEF @0x104, one cycle each.
//     -> boot_done=1 and cpu_stall=0 the cycle after the 2nd write.
//     -> exactly 12 pops.
//  3. Header 00 00 00 00 -> S_RUN after 4 pops, no mem_we pulse, len_err=0.
//  4. Test 2 bytes delivered with rx_empty=1 gaps of 0..3 random cycles
//     -> identical writes; no pop while rx_empty=1.
//  5. MAX_WORDS=2, header 03 00 00 00 followed by 12 data bytes
//     -> len_err=1, 2 writes, 4 bytes left in FIFO, boot_done=1.
//  6. rst pulse after 6 bytes of test 2, then resend the full stream
//     -> first write is still 0x12345678 @0x100; no write before the resend.

Source files
------------

// File: rtl/boot_loader_arb.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader_arb
//  Description : Shares the data-memory port and the UART RX FIFO pop line
//                between the CPU load/store path and a boot loader. With
//                boot_en_i=1 after reset, a little-endian length header and
//                then that many 32-bit words are streamed from the RX FIFO
//                into RAM starting at BASE_ADDR while the CPU is stalled.
//                Once loading ends (or straight away with boot_en_i=0) every
//                CPU memory/FIFO signal passes through combinationally.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock, synchronous active-high reset
//    boot_en_i         sampled in idle: 1 = run the loader, 0 = run the CPU
//    cpu_*_i           CPU data-side request (address, data, strobes, width)
//    cpu_rx_rdreq_i    FIFO pop requested on behalf of the CPU
//    rx_empty_i        show-ahead RX FIFO empty flag
//    rx_data_i         RX FIFO head byte, valid while rx_empty_i=0
//    rx_rdreq_o        RX FIFO pop
//    mem_*_o           request to the memory block
//    cpu_stall_o       1 = CPU holds its PC and pipeline
//    boot_done_o       sticky, set once the CPU is released
//    len_err_o         sticky, header length was above MAX_WORDS
// ============================================================================
module boot_loader_arb #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter logic [15:0] MAX_WORDS = 16'd8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_en_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic        cpu_re_i,
  input  logic [2:0]  cpu_funct3_i,
  input  logic        cpu_rx_rdreq_i,
  input  logic        rx_empty_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_rdreq_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  output logic [2:0]  mem_funct3_o,
  output logic        cpu_stall_o,
  output logic        boot_done_o,
  output logic        len_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;        // byte position within header/word
  logic [31:0] word_q, word_d;        // byte assembly register
  logic [15:0] nwords_q, nwords_d;    // clamped word count
  logic [15:0] widx_q, widx_d;        // index of the next word to write
  logic        wr_pend_q, wr_pend_d;  // write issues on the cycle after byte 3
  logic [31:0] wr_data_q, wr_data_d;  // frozen copy so the next word can start
  logic        boot_done_q, boot_done_d;
  logic        len_err_q, len_err_d;

  logic        w_pop;
  logic        w_last_pend;

  // The pending write belongs to word widx_q; if that is the final word,
  // its last byte has already been taken and the FIFO must not be touched.
  assign w_last_pend = wr_pend_q && (widx_q == (nwords_q - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bcnt_q      <= 2'd0;
      word_q      <= 32'd0;
      nwords_q    <= 16'd0;
      widx_q      <= 16'd0;
      wr_pend_q   <= 1'b0;
      wr_data_q   <= 32'd0;
      boot_done_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      nwords_q    <= nwords_d;
      widx_q      <= widx_d;
      wr_pend_q   <= wr_pend_d;
      wr_data_q   <= wr_data_d;
      boot_done_q <= boot_done_d;
      len_err_q   <= len_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    nwords_d  = nwords_q;
    widx_d    = widx_q;
    wr_pend_d = 1'b0;
    wr_data_d = wr_data_q;
    len_err_d = len_err_q;
    w_pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = boot_en_i ? S_HDR : S_RUN;
      end

      S_HDR: begin
        w_pop = ~rx_empty_i;
        if (w_pop) begin
          word_d[{bcnt_q, 3'b000} +: 8] = rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (word_d == 32'd0) begin
              state_d = S_RUN;
            end else begin
              if (word_d > {16'd0, MAX_WORDS}) begin
                nwords_d  = MAX_WORDS;
                len_err_d = 1'b1;
              end else begin
                nwords_d = word_d[15:0];
              end
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        w_pop = ~rx_empty_i & ~w_last_pend;
        if (wr_pend_q) begin
          widx_d = widx_q + 16'd1;
          if (w_last_pend) begin
            state_d = S_RUN;
          end
        end
        if (w_pop) begin
          word_d[{bcnt_q, 3'b000} +: 8] = rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wr_pend_d = 1'b1;
            wr_data_d = word_d;
          end
        end
      end

      S_RUN: begin
        state_d = S_RUN;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    boot_done_d = boot_done_q | (state_d == S_RUN);
  end

  // Output routing: CPU passthrough once running, loader write otherwise.
  always_comb begin
    rx_rdreq_o   = w_pop;
    mem_addr_o   = 32'd0;
    mem_wdata_o  = 32'd0;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    mem_funct3_o = 3'b000;
    if (state_q == S_RUN) begin
      rx_rdreq_o   = cpu_rx_rdreq_i;
      mem_addr_o   = cpu_addr_i;
      mem_wdata_o  = cpu_wdata_i;
      mem_we_o     = cpu_we_i;
      mem_re_o     = cpu_re_i;
      mem_funct3_o = cpu_funct3_i;
    end else if (wr_pend_q) begin
      mem_addr_o   = BASE_ADDR + {14'd0, widx_q, 2'b00};
      mem_wdata_o  = wr_data_q;
      mem_we_o     = 1'b1;
      mem_funct3_o = 3'b010;
    end
  end

  assign cpu_stall_o = (state_q != S_RUN);
  assign boot_done_o = boot_done_q;
  assign len_err_o   = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_loader_arb
//  Description : Self-checking bench for boot_loader_arb (MAX_WORDS=2).
//                Models the show-ahead RX FIFO as a byte queue, logs every
//                loader write, and compares against expectations derived
//                from the byte stream (header length, clamping, LE words).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_boot_loader_arb;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [15:0] MAXW = 16'd2;

  logic        clk, rst, boot_en;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_we, cpu_re, cpu_rx_rdreq;
  logic [2:0]  cpu_funct3;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_rdreq_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_we_o, mem_re_o;
  logic [2:0]  mem_funct3_o;
  logic        cpu_stall_o, boot_done_o, len_err_o;

  boot_loader_arb #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .boot_en_i(boot_en),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_we_i(cpu_we),
    .cpu_re_i(cpu_re), .cpu_funct3_i(cpu_funct3), .cpu_rx_rdreq_i(cpu_rx_rdreq),
    .rx_empty_i(rx_empty), .rx_data_i(rx_data), .rx_rdreq_o(rx_rdreq_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .mem_funct3_o(mem_funct3_o), .cpu_stall_o(cpu_stall_o),
    .boot_done_o(boot_done_o), .len_err_o(len_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model and write monitor ----------------
  typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} wr_t;
  logic [7:0] fifo[$];
  wr_t        wlog[$];
  int         pops, gap_cnt, cyc, done_cyc;
  bit         gaps_en, mon_en;

  task automatic refresh();
    rx_empty = (gap_cnt > 0) || (fifo.size() == 0);
    rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  initial begin
    bit pop_now;
    forever begin
      @(negedge clk);
      cyc++;
      pop_now = rx_rdreq_o && !rx_empty;
      if (mon_en && cpu_stall_o) begin
        chk("pop_while_empty", {31'd0, rx_rdreq_o & rx_empty}, 32'd0);
        if (mem_we_o) begin
          wlog.push_back('{mem_addr_o, mem_wdata_o, cyc});
          chk("wr_re", {31'd0, mem_re_o}, 32'd0);
          chk("wr_funct3", {29'd0, mem_funct3_o}, 32'd2);
        end else begin
          chk("idle_mem", mem_addr_o | mem_wdata_o | {29'd0, mem_funct3_o} | {31'd0, mem_re_o}, 32'd0);
        end
      end
      if (mon_en && boot_done_o && done_cyc < 0) done_cyc = cyc;
      @(posedge clk);
      #1;
      if (pop_now) begin
        void'(fifo.pop_front());
        pops++;
      end
      if (gap_cnt > 0) gap_cnt--;
      else if (gaps_en && pop_now) gap_cnt = $urandom_range(0, 3);
      refresh();
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit ben);
    rst = 1'b1;
    boot_en = ben;
    cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_re = 0; cpu_funct3 = 0; cpu_rx_rdreq = 0;
    gaps_en = 1'b0;
    step();
    step();
    fifo.delete();
    wlog.delete();
    pops = 0;
    gap_cnt = 0;
    done_cyc = -1;
    mon_en = 1'b1;
    refresh();
  endtask

  task automatic push(input logic [7:0] s[$]);
    foreach (s[i]) fifo.push_back(s[i]);
    refresh();
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_rst_stall"}, {31'd0, cpu_stall_o}, 32'd1);
    chk({tag, "_rst_done"},  {31'd0, boot_done_o}, 32'd0);
    chk({tag, "_rst_lenerr"}, {31'd0, len_err_o},  32'd0);
    chk({tag, "_rst_we"},    {31'd0, mem_we_o},    32'd0);
    chk({tag, "_rst_rdreq"}, {31'd0, rx_rdreq_o},  32'd0);
  endtask

  // Full load: expectations come from the byte stream alone.
  task automatic load_and_check(input string tag, input logic [7:0] s[$], input bit gaps);
    logic [31:0] len, ed;
    int n, budget, nexp;
    bit err;
    len = {s[3], s[2], s[1], s[0]};
    err = (len > {16'd0, MAXW});
    n   = err ? int'(MAXW) : int'(len);
    nexp = 4 + 4 * n;
    do_reset(1'b1);
    push(s);
    chk_reset(tag);
    step();
    gaps_en = gaps;
    rst = 1'b0;
    budget = 0;
    while (cpu_stall_o && budget < 600) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_timeout"}, {31'd0, cpu_stall_o}, 32'd0);
    repeat (3) @(negedge clk);
    gaps_en = 1'b0;
    chk({tag, "_nwrites"}, wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size(); i++) begin
      ed = {s[4*i+7], s[4*i+6], s[4*i+5], s[4*i+4]};
      chk({tag, "_waddr"}, wlog[i].addr, BASE + 32'(4 * i));
      chk({tag, "_wdata"}, wlog[i].data, ed);
    end
    chk({tag, "_pops"}, pops, nexp);
    chk({tag, "_left"}, fifo.size(), s.size() - nexp);
    chk({tag, "_lenerr"}, {31'd0, len_err_o}, {31'd0, err});
    chk({tag, "_done"}, {31'd0, boot_done_o}, 32'd1);
    if (n > 0 && wlog.size() > 0)
      chk({tag, "_done_cyc"}, done_cyc, wlog[wlog.size()-1].cyc + 1);
  endtask

  // ---------------- table-driven routing vectors ----------------
  typedef struct {
    logic [31:0] addr; logic [31:0] wdata; logic we; logic re; logic [2:0] f3; logic rxrd;
    logic [31:0] e_addr; logic [31:0] e_wdata; logic e_we; logic e_re; logic [2:0] e_f3; logic e_rxrd;
  } vec_t;

  initial begin
    vec_t        vr[5];
    logic [7:0]  s[$];
    int          b;
    mon_en = 1'b0;
    fifo.delete();
    gap_cnt = 0;
    refresh();

    vr[0] = '{32'h20, 32'hCAFE_0001, 1, 0, 3'b010, 0, 32'h20, 32'hCAFE_0001, 1, 0, 3'b010, 0};
    vr[1] = '{32'h44, 32'h0, 0, 1, 3'b100, 0, 32'h44, 32'h0, 0, 1, 3'b100, 0};
    vr[2] = '{32'hFFFF_FFFC, 32'hA5A5_5A5A, 1, 1, 3'b001, 1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 1, 1, 3'b001, 1};
    vr[3] = '{32'h0, 32'h0, 0, 0, 3'b000, 1, 32'h0, 32'h0, 0, 0, 3'b000, 1};
    vr[4] = '{32'h1234_5678, 32'h8765_4321, 1, 0, 3'b111, 0, 32'h1234_5678, 32'h8765_4321, 1, 0, 3'b111, 0};

    // Test 1: boot_en=0 -> S_RUN one cycle after reset release, passthrough.
    do_reset(1'b0);
    s = '{8'h11, 8'h22};
    push(s);
    chk_reset("t1");
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_idle_stall", {31'd0, cpu_stall_o}, 32'd1);
    chk("t1_idle_done",  {31'd0, boot_done_o}, 32'd0);
    @(negedge clk);
    chk("t1_run_stall", {31'd0, cpu_stall_o}, 32'd0);
    chk("t1_run_done",  {31'd0, boot_done_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      cpu_addr = vr[i].addr; cpu_wdata = vr[i].wdata; cpu_we = vr[i].we;
      cpu_re = vr[i].re; cpu_funct3 = vr[i].f3; cpu_rx_rdreq = vr[i].rxrd;
      @(negedge clk);
      chk("run_addr",  mem_addr_o,  vr[i].e_addr);
      chk("run_wdata", mem_wdata_o, vr[i].e_wdata);
      chk("run_we",    {31'd0, mem_we_o}, {31'd0, vr[i].e_we});
      chk("run_re",    {31'd0, mem_re_o}, {31'd0, vr[i].e_re});
      chk("run_f3",    {29'd0, mem_funct3_o}, {29'd0, vr[i].e_f3});
      chk("run_rxrd",  {31'd0, rx_rdreq_o}, {31'd0, vr[i].e_rxrd});
    end

    // Same table while the loader waits on an empty FIFO: CPU is ignored.
    do_reset(1'b1);
    step();
    rst = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      cpu_addr = vr[i].addr; cpu_wdata = vr[i].wdata; cpu_we = vr[i].we;
      cpu_re = vr[i].re; cpu_funct3 = vr[i].f3; cpu_rx_rdreq = vr[i].rxrd;
      @(negedge clk);
      chk("hdr_stall", {31'd0, cpu_stall_o}, 32'd1);
      chk("hdr_we",    {31'd0, mem_we_o}, 32'd0);
      chk("hdr_rxrd",  {31'd0, rx_rdreq_o}, 32'd0);
    end

    // Test 2, 3, 4, 5.
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_and_check("t2", s, 1'b0);
    chk("t2_w0", wlog.size() > 0 ? wlog[0].data : 32'h0, 32'h1234_5678);
    load_and_check("t4", s, 1'b1);
    s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h99};
    load_and_check("t3", s, 1'b0);
    s = '{8'h03, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 12; i++) s.push_back(8'(8'h30 + i));
    load_and_check("t5", s, 1'b0);
    s = '{8'h02, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 10; i++) s.push_back(8'(8'hA0 + i));
    load_and_check("hi_len", s, 1'b1);

    // Test 6: reset after 6 bytes, then resend the whole stream.
    do_reset(1'b1);
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56};
    push(s);
    step();
    rst = 1'b0;
    b = 0;
    while (pops < 6 && b < 200) begin
      step();
      b++;
    end
    chk("t6_six_pops", pops, 6);
    rst = 1'b1;
    step();
    chk("t6_no_early_write", wlog.size(), 0);
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_and_check("t6", s, 1'b0);
    chk("t6_w0", wlog.size() > 0 ? wlog[0].addr : 32'h0, 32'h100);

    // Randomized loads.
    for (int t = 0; t < 12; t++) begin
      int len, nb;
      len = $urandom_range(0, 4);
      nb  = 4 * ((len > 3) ? 3 : len) + $urandom_range(0, 5);
      s = '{8'(len), 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < nb; i++) s.push_back(8'($urandom_range(0, 255)));
      load_and_check("rnd", s, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
